pt_axi4lite_initiator: RTL
==========================

Name: pt_axi4lite_initiator

Overview:
- AXI4-Lite manager: the initiating end of the AXI4-Lite links that our register-file bridges terminate.
- Accepts single-beat register requests on a simple valid/ready port and issues them as AXI4-Lite write or read transactions.
- Returns read data and response status on a valid/ready response port.
- Used by test harnesses, boot sequencers and debug masters to drive generated register files over AXI4-Lite; at most one transaction is outstanding.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 64, data width; must be 32 or 64
- STRB_W, DATA_W/8, write strobe width (localparam)
- PROT, 3'b000, constant driven on o_awprot/o_arprot
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- i_req_address  in  ADDR_W  request address
- i_req_wr_data  in  DATA_W  write data
- i_req_wr_strb  in  STRB_W  write byte strobes
- i_req_write  in  1  1=write, 0=read
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- o_rsp_rd_data  out  DATA_W  read data (0 for writes)
- o_rsp_resp  out  2  raw BRESP/RRESP (2'b10 on timeout)
- o_rsp_error  out  1  o_rsp_resp != 2'b00
- o_rsp_write  out  1  echoes the request type
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed
- o_awaddr, o_awprot, o_awvalid, i_awready: AXI write-address channel
- o_wdata, o_wstrb, o_wvalid, i_wready: AXI write-data channel
- i_bresp, i_bvalid, o_bready: AXI write-response channel
- o_araddr, o_arprot, o_arvalid, i_arready: AXI read-address channel
- i_rdata, i_rresp, i_rvalid, o_rready: AXI read-data channel

Behaviour:
- Reset: when i_rst is low, every output goes to 0 asynchronously; the FSM enters IDLE.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESPOND.
- IDLE:
  - o_req_ready=1; in every other state o_req_ready=0.
  - On the request handshake, register the address, data, strobe and type. Next state is WR_REQ or RD_REQ.
- WR_REQ:
  - o_awvalid and o_wvalid assert together in the cycle after acceptance.
  - Each valid drops independently in the cycle after its own handshake.
  - awready/wready may arrive in any order or in the same cycle.
  - Move to WR_RESP once both handshakes have completed (tracked with aw_done/w_done flags).
- WR_RESP: o_bready=1. On bvalid, capture bresp and go to RESPOND.
- RD_REQ: o_arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: o_rready=1. On rvalid, capture rdata and rresp and go to RESPOND.
- RESPOND:
  - o_rsp_valid=1; the response fields are held stable until i_rsp_ready.
  - Then return to IDLE; o_rsp_valid drops the following cycle.
- AXI source stability: AXI address, data, strobe and prot outputs are driven from the request registers and are stable while their valid is high. A valid is never withdrawn before its ready (no-timeout build).
- Minimum latency, with zero-wait-state subordinates:
  - Write: request accepted in cycle N; AW/W handshake at N+1; B at N+2; o_rsp_valid at N+3.
  - Read: AR at N+1; R at N+2; o_rsp_valid at N+3.
  - Back-to-back throughput: one transaction per 4 cycles.
- Ready gating: o_bready and o_rready are high only in WR_RESP and RD_RESP respectively. Beats arriving earlier are not accepted.
- Response rules:
  - For writes, o_rsp_rd_data=0.
  - Any non-OKAY response (SLVERR 2'b10, DECERR 2'b11, EXOKAY 2'b01) sets o_rsp_error=1. AXI4-Lite does not permit EXOKAY, so it is flagged.
- Reset mid-transaction: all valids and readies drop immediately and the in-flight request is discarded. No response is produced.

Optional Feature:
- Macro: PT_AXI4LITE_INITIATOR_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counter starts at request acceptance and clears in IDLE.
  - If TIMEOUT_CYCLES elapse without reaching RESPOND, all AXI valids and readies are deasserted and the FSM goes to RESPOND with o_rsp_resp=2'b10, o_rsp_error=1, o_rsp_rd_data=0.
  - While in IDLE, o_bready and o_rready are held at 1 so stale B/R beats are sunk and discarded.
  - This is a debug recovery mechanism and knowingly breaks AXI valid-stability.
- When undefined: no counter; the FSM waits indefinitely and o_bready/o_rready are 0 in IDLE.

Test Plan:
- Write, addr 0x40, data 0xDEADBEEF_CAFEF00D, strb 0xFF, all readies high -> AW/W at N+1 with those values; o_rsp_valid at N+3 with error=0 and rd_data=0.
- Write, awready at N+1, wready held off until N+4 -> o_awvalid drops at N+2; o_wvalid stays high until N+4; B accepted only after the W handshake.
- Read, addr 0x08, rdata 0x1234, rresp=2'b10 -> o_rsp_rd_data=0x1234, o_rsp_resp=2'b10, o_rsp_error=1, o_rsp_write=0.
- Read response with i_rsp_ready low for 5 cycles -> response fields held stable, o_req_ready stays 0; a new request is accepted the cycle after i_rsp_ready rises.
- i_rst driven low while o_arvalid=1 and arready never given -> all outputs 0 immediately; IDLE with o_req_ready=1 after release; no response emitted.
- Timeout build, TIMEOUT_CYCLES=16, bvalid never asserted -> response with resp=2'b10 exactly 16 cycles after acceptance; a later stray bvalid is sunk in IDLE.

Source files
------------

// File: rtl/pt_axi4lite_initiator_if.sv
// AXI4-Lite link between an initiator (master modport) and a
// subordinate (slave modport). Carries the five AXI4-Lite channels only.
interface pt_axi4lite_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/pt_axi4lite_initiator.sv
// AXI4-Lite initiator: turns single-beat valid/ready register requests into
// AXI4-Lite write/read transactions, one outstanding at a time, and returns
// status/read data on a valid/ready response port. All outputs registered.
// Optional watchdog: define PT_AXI4LITE_INITIATOR_TIMEOUT_EN to abort a stuck
// transaction after TIMEOUT_CYCLES with resp=2'b10 and to sink stray B/R beats
// while idle.
module pt_axi4lite_initiator #(
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 64,
    parameter logic [2:0] PROT           = 3'b000,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ADDR_W-1:0]    i_req_address,
    input  logic [DATA_W-1:0]    i_req_wr_data,
    input  logic [DATA_W/8-1:0]  i_req_wr_strb,
    input  logic                 i_req_write,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    output logic [DATA_W-1:0]    o_rsp_rd_data,
    output logic [1:0]           o_rsp_resp,
    output logic                 o_rsp_error,
    output logic                 o_rsp_write,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    pt_axi4lite_initiator_if.master axi
);
    localparam int STRB_W = DATA_W / 8;

`ifdef PT_AXI4LITE_INITIATOR_TIMEOUT_EN
    localparam logic IDLE_SINK = 1'b1;
`else
    localparam logic IDLE_SINK = 1'b0;
    localparam int   unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESPOND} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [2:0]        prot_q;
    logic              write_q;
    logic              aw_done, w_done;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
`ifdef PT_AXI4LITE_INITIATOR_TIMEOUT_EN
    logic [15:0]       wd_cnt;
`endif

    // AXI sources come straight from the request registers, so they are
    // stable for as long as the matching valid is high.
    assign axi.awaddr  = addr_q;
    assign axi.araddr  = addr_q;
    assign axi.awprot  = prot_q;
    assign axi.arprot  = prot_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q  & axi.wready;
    assign ar_hs = arvalid_q & axi.arready;

    // Transaction FSM with registered outputs; each next-state decision also
    // sets the outputs that state presents.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            prot_q        <= '0;
            write_q       <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            o_req_ready   <= 1'b0;
            o_rsp_rd_data <= '0;
            o_rsp_resp    <= '0;
            o_rsp_error   <= 1'b0;
            o_rsp_write   <= 1'b0;
            o_rsp_valid   <= 1'b0;
`ifdef PT_AXI4LITE_INITIATOR_TIMEOUT_EN
            wd_cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_req_ready <= 1'b1;
                    bready_q    <= IDLE_SINK;
                    rready_q    <= IDLE_SINK;
`ifdef PT_AXI4LITE_INITIATOR_TIMEOUT_EN
                    wd_cnt      <= '0;
`endif
                    if (i_req_valid && o_req_ready) begin
                        o_req_ready <= 1'b0;
                        bready_q    <= 1'b0;
                        rready_q    <= 1'b0;
                        addr_q      <= i_req_address;
                        wdata_q     <= i_req_wr_data;
                        wstrb_q     <= i_req_wr_strb;
                        prot_q      <= PROT;
                        write_q     <= i_req_write;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
`ifdef PT_AXI4LITE_INITIATOR_TIMEOUT_EN
                        wd_cnt      <= 16'd1;
`endif
                        if (i_req_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q      <= 1'b0;
                        o_rsp_rd_data <= '0;
                        o_rsp_resp    <= axi.bresp;
                        o_rsp_error   <= |axi.bresp;
                        o_rsp_write   <= 1'b1;
                        o_rsp_valid   <= 1'b1;
                        state         <= RESPOND;
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi.rvalid) begin
                        rready_q      <= 1'b0;
                        o_rsp_rd_data <= axi.rdata;
                        o_rsp_resp    <= axi.rresp;
                        o_rsp_error   <= |axi.rresp;
                        o_rsp_write   <= 1'b0;
                        o_rsp_valid   <= 1'b1;
                        state         <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        bready_q    <= IDLE_SINK;
                        rready_q    <= IDLE_SINK;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PT_AXI4LITE_INITIATOR_TIMEOUT_EN
            // Watchdog overrides whatever the channel states decided: wd_cnt
            // equals cycles since acceptance, so the response appears exactly
            // TIMEOUT_CYCLES after the request handshake.
            if (state != IDLE && state != RESPOND) begin
                wd_cnt <= wd_cnt + 16'd1;
                if (wd_cnt >= 16'(TIMEOUT_CYCLES - 1)) begin
                    awvalid_q     <= 1'b0;
                    wvalid_q      <= 1'b0;
                    bready_q      <= 1'b0;
                    arvalid_q     <= 1'b0;
                    rready_q      <= 1'b0;
                    o_rsp_rd_data <= '0;
                    o_rsp_resp    <= 2'b10;
                    o_rsp_error   <= 1'b1;
                    o_rsp_write   <= write_q;
                    o_rsp_valid   <= 1'b1;
                    state         <= RESPOND;
                end
            end
`endif
        end
    end
endmodule
